// File: rtl/reorder_buffer.sv
// In-order reorder buffer: 2-wide dispatch, three completion ports with same-cycle
// forwarding, and up to two in-order retirements per cycle.
module reorder_buffer #(
    parameter int  ROB_DEPTH = 64,
    parameter int  PREG_W    = 7,
    localparam int IW        = $clog2(ROB_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              disp_a_valid,
    input  logic [31:0]       disp_a_pc,
    input  logic [4:0]        disp_a_arch_rd,
    input  logic [PREG_W-1:0] disp_a_phys_rd,
    input  logic [PREG_W-1:0] disp_a_old_phys_rd,
    input  logic              disp_a_reg_write,
    input  logic              disp_a_is_store,
    input  logic              disp_b_valid,
    input  logic [31:0]       disp_b_pc,
    input  logic [4:0]        disp_b_arch_rd,
    input  logic [PREG_W-1:0] disp_b_phys_rd,
    input  logic [PREG_W-1:0] disp_b_old_phys_rd,
    input  logic              disp_b_reg_write,
    input  logic              disp_b_is_store,

    output logic [IW-1:0]     alloc_idx_a,
    output logic [IW-1:0]     alloc_idx_b,
    output logic              rob_full,

    input  logic              comp0_valid,
    input  logic [IW-1:0]     comp0_rob_idx,
    input  logic [31:0]       comp0_value,
    input  logic [31:0]       comp0_mem_addr,
    input  logic              comp1_valid,
    input  logic [IW-1:0]     comp1_rob_idx,
    input  logic [31:0]       comp1_value,
    input  logic [31:0]       comp1_mem_addr,
    input  logic              comp2_valid,
    input  logic [IW-1:0]     comp2_rob_idx,
    input  logic [31:0]       comp2_value,
    input  logic [31:0]       comp2_mem_addr,

    output logic              fwd_a_valid,
    output logic [PREG_W-1:0] fwd_a_phys_rd,
    output logic [31:0]       fwd_a_value,
    output logic              fwd_b_valid,
    output logic [PREG_W-1:0] fwd_b_phys_rd,
    output logic [31:0]       fwd_b_value,
    output logic              fwd_c_valid,
    output logic [PREG_W-1:0] fwd_c_phys_rd,
    output logic [31:0]       fwd_c_value,

    output logic              ret_a_valid,
    output logic [31:0]       ret_a_pc,
    output logic [4:0]        ret_a_arch_rd,
    output logic [PREG_W-1:0] ret_a_phys_rd,
    output logic [PREG_W-1:0] ret_a_old_phys_rd,
    output logic              ret_a_reg_write,
    output logic              ret_a_is_store,
    output logic [31:0]       ret_a_value,
    output logic [31:0]       ret_a_mem_addr,
    output logic              ret_b_valid,
    output logic [31:0]       ret_b_pc,
    output logic [4:0]        ret_b_arch_rd,
    output logic [PREG_W-1:0] ret_b_phys_rd,
    output logic [PREG_W-1:0] ret_b_old_phys_rd,
    output logic              ret_b_reg_write,
    output logic              ret_b_is_store,
    output logic [31:0]       ret_b_value,
    output logic [31:0]       ret_b_mem_addr
);

    typedef struct packed {
        logic [31:0]       pc;
        logic [4:0]        arch_rd;
        logic [PREG_W-1:0] phys_rd;
        logic [PREG_W-1:0] old_phys_rd;
        logic              reg_write;
        logic              is_store;
        logic [31:0]       value;
        logic [31:0]       mem_addr;
    } entry_t;

    typedef struct packed {
        logic   valid;
        entry_t ent;
    } ret_t;

    entry_t               ent_q [ROB_DEPTH];
    entry_t               ent_d [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] done_q, done_d;
    logic [IW-1:0]        head_q, head_d, tail_q, tail_d, head1;
    logic [IW:0]          count_q, count_d;
    ret_t                 ret_a_q, ret_a_d, ret_b_q, ret_b_d;
    logic [1:0]           n_ret, n_disp;

    logic                 c_vld [3];
    logic [IW-1:0]        c_idx [3];
    logic [31:0]          c_val [3];
    logic [31:0]          c_ma  [3];
    logic                 c_hit [3];

    function automatic logic occupied(input logic [IW-1:0] idx, input logic [IW-1:0] hd,
                                      input logic [IW:0] cnt);
        logic [IW-1:0] off;
        off = idx - hd;
        return {1'b0, off} < cnt;
    endfunction

    function automatic entry_t disp_entry(input logic [31:0] pc, input logic [4:0] rd,
                                          input logic [PREG_W-1:0] prd,
                                          input logic [PREG_W-1:0] oprd,
                                          input logic rw, input logic st);
        entry_t e;
        e             = '0;
        e.pc          = pc;
        e.arch_rd     = rd;
        e.phys_rd     = prd;
        e.old_phys_rd = oprd;
        e.reg_write   = rw;
        e.is_store    = st;
        return e;
    endfunction

    always_comb begin
        c_vld[0] = comp0_valid; c_idx[0] = comp0_rob_idx; c_val[0] = comp0_value; c_ma[0] = comp0_mem_addr;
        c_vld[1] = comp1_valid; c_idx[1] = comp1_rob_idx; c_val[1] = comp1_value; c_ma[1] = comp1_mem_addr;
        c_vld[2] = comp2_valid; c_idx[2] = comp2_rob_idx; c_val[2] = comp2_value; c_ma[2] = comp2_mem_addr;
        for (int i = 0; i < 3; i++) begin
            c_hit[i] = c_vld[i] && occupied(c_idx[i], head_q, count_q);
        end
    end

    // Full is raised while two slots are still free, so a 2-wide dispatch never overfills.
    assign rob_full    = count_q >= (IW+1)'(ROB_DEPTH - 2);
    assign alloc_idx_a = tail_q;
    assign alloc_idx_b = disp_a_valid ? tail_q + IW'(1) : tail_q;

    assign fwd_a_valid   = c_hit[0] && ent_q[c_idx[0]].reg_write;
    assign fwd_a_phys_rd = ent_q[c_idx[0]].phys_rd;
    assign fwd_a_value   = comp0_value;
    assign fwd_b_valid   = c_hit[1] && ent_q[c_idx[1]].reg_write;
    assign fwd_b_phys_rd = ent_q[c_idx[1]].phys_rd;
    assign fwd_b_value   = comp1_value;
    assign fwd_c_valid   = c_hit[2] && ent_q[c_idx[2]].reg_write;
    assign fwd_c_phys_rd = ent_q[c_idx[2]].phys_rd;
    assign fwd_c_value   = comp2_value;

    always_comb begin
        ent_d   = ent_q;
        done_d  = done_q;
        ret_a_d = '0;
        ret_b_d = '0;
        n_ret   = 2'd0;
        n_disp  = 2'd0;
        head1   = head_q + IW'(1);

        // Retire looks only at done bits already registered, never this cycle's completions.
        if (count_q != '0 && done_q[head_q]) begin
            ret_a_d = '{valid: 1'b1, ent: ent_q[head_q]};
            n_ret   = 2'd1;
            if (count_q > (IW+1)'(1) && done_q[head1]) begin
                ret_b_d = '{valid: 1'b1, ent: ent_q[head1]};
                n_ret   = 2'd2;
            end
        end

        // Later ports overwrite earlier ones on a shared index.
        for (int i = 0; i < 3; i++) begin
            if (c_hit[i]) begin
                done_d[c_idx[i]]          = 1'b1;
                ent_d[c_idx[i]].value     = c_val[i];
                ent_d[c_idx[i]].mem_addr  = c_ma[i];
            end
        end

        if (ret_a_d.valid) done_d[head_q] = 1'b0;
        if (ret_b_d.valid) done_d[head1]  = 1'b0;

        if (!rob_full) begin
            if (disp_a_valid) begin
                ent_d[alloc_idx_a]  = disp_entry(disp_a_pc, disp_a_arch_rd, disp_a_phys_rd,
                                                 disp_a_old_phys_rd, disp_a_reg_write, disp_a_is_store);
                done_d[alloc_idx_a] = 1'b0;
                n_disp              = n_disp + 2'd1;
            end
            if (disp_b_valid) begin
                ent_d[alloc_idx_b]  = disp_entry(disp_b_pc, disp_b_arch_rd, disp_b_phys_rd,
                                                 disp_b_old_phys_rd, disp_b_reg_write, disp_b_is_store);
                done_d[alloc_idx_b] = 1'b0;
                n_disp              = n_disp + 2'd1;
            end
        end

        head_d  = head_q + IW'(n_ret);
        tail_d  = tail_q + IW'(n_disp);
        count_d = count_q + (IW+1)'(n_disp) - (IW+1)'(n_ret);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_q   <= '{default: '0};
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ret_a_q <= '0;
            ret_b_q <= '0;
        end else begin
            ent_q   <= ent_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ret_a_q <= ret_a_d;
            ret_b_q <= ret_b_d;
        end
    end

    assign ret_a_valid       = ret_a_q.valid;
    assign ret_a_pc          = ret_a_q.ent.pc;
    assign ret_a_arch_rd     = ret_a_q.ent.arch_rd;
    assign ret_a_phys_rd     = ret_a_q.ent.phys_rd;
    assign ret_a_old_phys_rd = ret_a_q.ent.old_phys_rd;
    assign ret_a_reg_write   = ret_a_q.ent.reg_write;
    assign ret_a_is_store    = ret_a_q.ent.is_store;
    assign ret_a_value       = ret_a_q.ent.value;
    assign ret_a_mem_addr    = ret_a_q.ent.mem_addr;
    assign ret_b_valid       = ret_b_q.valid;
    assign ret_b_pc          = ret_b_q.ent.pc;
    assign ret_b_arch_rd     = ret_b_q.ent.arch_rd;
    assign ret_b_phys_rd     = ret_b_q.ent.phys_rd;
    assign ret_b_old_phys_rd = ret_b_q.ent.old_phys_rd;
    assign ret_b_reg_write   = ret_b_q.ent.reg_write;
    assign ret_b_is_store    = ret_b_q.ent.is_store;
    assign ret_b_value       = ret_b_q.ent.value;
    assign ret_b_mem_addr    = ret_b_q.ent.mem_addr;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized traffic, checked against
// a program-order queue model of the buffer.
module tb_reorder_buffer;

    localparam int IW = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        da_v, da_rw, da_st, db_v, db_rw, db_st;
    logic [31:0] da_pc, db_pc;
    logic [4:0]  da_rd, db_rd;
    logic [6:0]  da_p, da_op, db_p, db_op;
    logic [IW-1:0] alloc_a, alloc_b;
    logic        full;
    logic        c_v [3];
    logic [IW-1:0] c_i [3];
    logic [31:0] c_val [3], c_ma [3];
    logic        f_v [3];
    logic [6:0]  f_p [3];
    logic [31:0] f_val [3];
    logic        ra_v, ra_rw, ra_st, rb_v, rb_rw, rb_st;
    logic [31:0] ra_pc, ra_val, ra_ma, rb_pc, rb_val, rb_ma;
    logic [4:0]  ra_rd, rb_rd;
    logic [6:0]  ra_p, ra_op, rb_p, rb_op;

    reorder_buffer #(.ROB_DEPTH(64), .PREG_W(7)) dut (
        .clk(clk), .reset(reset),
        .disp_a_valid(da_v), .disp_a_pc(da_pc), .disp_a_arch_rd(da_rd), .disp_a_phys_rd(da_p),
        .disp_a_old_phys_rd(da_op), .disp_a_reg_write(da_rw), .disp_a_is_store(da_st),
        .disp_b_valid(db_v), .disp_b_pc(db_pc), .disp_b_arch_rd(db_rd), .disp_b_phys_rd(db_p),
        .disp_b_old_phys_rd(db_op), .disp_b_reg_write(db_rw), .disp_b_is_store(db_st),
        .alloc_idx_a(alloc_a), .alloc_idx_b(alloc_b), .rob_full(full),
        .comp0_valid(c_v[0]), .comp0_rob_idx(c_i[0]), .comp0_value(c_val[0]), .comp0_mem_addr(c_ma[0]),
        .comp1_valid(c_v[1]), .comp1_rob_idx(c_i[1]), .comp1_value(c_val[1]), .comp1_mem_addr(c_ma[1]),
        .comp2_valid(c_v[2]), .comp2_rob_idx(c_i[2]), .comp2_value(c_val[2]), .comp2_mem_addr(c_ma[2]),
        .fwd_a_valid(f_v[0]), .fwd_a_phys_rd(f_p[0]), .fwd_a_value(f_val[0]),
        .fwd_b_valid(f_v[1]), .fwd_b_phys_rd(f_p[1]), .fwd_b_value(f_val[1]),
        .fwd_c_valid(f_v[2]), .fwd_c_phys_rd(f_p[2]), .fwd_c_value(f_val[2]),
        .ret_a_valid(ra_v), .ret_a_pc(ra_pc), .ret_a_arch_rd(ra_rd), .ret_a_phys_rd(ra_p),
        .ret_a_old_phys_rd(ra_op), .ret_a_reg_write(ra_rw), .ret_a_is_store(ra_st),
        .ret_a_value(ra_val), .ret_a_mem_addr(ra_ma),
        .ret_b_valid(rb_v), .ret_b_pc(rb_pc), .ret_b_arch_rd(rb_rd), .ret_b_phys_rd(rb_p),
        .ret_b_old_phys_rd(rb_op), .ret_b_reg_write(rb_rw), .ret_b_is_store(rb_st),
        .ret_b_value(rb_val), .ret_b_mem_addr(rb_ma)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [6:0]  p, op;
        logic        rw, st, done;
        logic [31:0] val, ma;
        int          idx;
    } ent_t;

    ent_t mq[$];
    int   total, n_checks, n_errors, dut_retired, model_accepted, prev_alloc;
    bit   seen_wrap;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int find(input logic [IW-1:0] idx);
        foreach (mq[i]) if (mq[i].idx == int'(idx)) return i;
        return -1;
    endfunction

    task automatic clear_in();
        da_v = 0; da_pc = 0; da_rd = 0; da_p = 0; da_op = 0; da_rw = 0; da_st = 0;
        db_v = 0; db_pc = 0; db_rd = 0; db_p = 0; db_op = 0; db_rw = 0; db_st = 0;
        for (int p = 0; p < 3; p++) begin
            c_v[p] = 0; c_i[p] = 0; c_val[p] = 0; c_ma[p] = 0;
        end
    endtask

    task automatic rand_disp(input bit force_both);
        da_v = force_both || ($urandom % 4 != 0); db_v = force_both || ($urandom % 4 != 0);
        da_pc = $urandom; da_rd = 5'($urandom); da_p = 7'($urandom); da_op = 7'($urandom);
        da_rw = 1'($urandom); da_st = 1'($urandom);
        db_pc = $urandom; db_rd = 5'($urandom); db_p = 7'($urandom); db_op = 7'($urandom);
        db_rw = 1'($urandom); db_st = 1'($urandom);
    endtask

    task automatic push_entry(input logic [31:0] pc, input logic [4:0] rd, input logic [6:0] p,
                              input logic [6:0] op, input logic rw, input logic st);
        ent_t e;
        e.pc = pc; e.rd = rd; e.p = p; e.op = op; e.rw = rw; e.st = st;
        e.done = 0; e.val = 0; e.ma = 0; e.idx = total % 64;
        mq.push_back(e);
        total++;
        model_accepted++;
    endtask

    // One clock: inputs are already driven after a falling edge.
    task automatic cycle();
        bit   fl, fv, rva, rvb;
        int   k;
        ent_t ea, eb;
        #1;
        fl = (mq.size() >= 62);
        check("rob_full", full, fl);
        check("alloc_a", alloc_a, total % 64);
        check("alloc_b", alloc_b, (total + (da_v ? 1 : 0)) % 64);
        if (int'(alloc_a) < prev_alloc) seen_wrap = 1;
        prev_alloc = int'(alloc_a);
        for (int p = 0; p < 3; p++) begin
            k  = find(c_i[p]);
            fv = c_v[p] && (k >= 0) && mq[k].rw;
            check("fwd_valid", f_v[p], fv);
            if (fv) begin
                check("fwd_phys", f_p[p], mq[k].p);
                check("fwd_value", f_val[p], c_val[p]);
            end
        end
        rva = (mq.size() > 0) && mq[0].done;
        rvb = rva && (mq.size() > 1) && mq[1].done;
        if (rva) ea = mq.pop_front();
        if (rvb) eb = mq.pop_front();
        for (int p = 0; p < 3; p++) begin
            if (c_v[p]) begin
                k = find(c_i[p]);
                if (k >= 0) begin
                    mq[k].done = 1; mq[k].val = c_val[p]; mq[k].ma = c_ma[p];
                end
            end
        end
        if (!fl) begin
            if (da_v) push_entry(da_pc, da_rd, da_p, da_op, da_rw, da_st);
            if (db_v) push_entry(db_pc, db_rd, db_p, db_op, db_rw, db_st);
        end
        @(posedge clk);
        #1;
        check("ret_a_valid", ra_v, rva);
        check("ret_b_valid", rb_v, rvb);
        if (ra_v) dut_retired++;
        if (rb_v) dut_retired++;
        if (rva) begin
            check("ret_a_pc", ra_pc, ea.pc);
            check("ret_a_value", ra_val, ea.val);
            check("ret_a_mem_addr", ra_ma, ea.ma);
            check("ret_a_fields", {ra_rd, ra_p, ra_op, ra_rw, ra_st}, {ea.rd, ea.p, ea.op, ea.rw, ea.st});
        end
        if (rvb) begin
            check("ret_b_pc", rb_pc, eb.pc);
            check("ret_b_value", rb_val, eb.val);
            check("ret_b_mem_addr", rb_ma, eb.ma);
            check("ret_b_fields", {rb_rd, rb_p, rb_op, rb_rw, rb_st}, {eb.rd, eb.p, eb.op, eb.rw, eb.st});
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1;
        #2;
        check("rst_ret_a_valid", ra_v, 0);
        check("rst_ret_b_valid", rb_v, 0);
        check("rst_rob_full", full, 0);
        check("rst_alloc_a", alloc_a, 0);
        check("rst_fwd_a", f_v[0], 0);
        model_accepted -= mq.size();
        mq.delete();
        total = 0;
        prev_alloc = 0;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic set_comp(input int p, input int idx, input logic [31:0] v);
        c_v[p] = 1; c_i[p] = IW'(idx); c_val[p] = v; c_ma[p] = v + 32'h1000;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; total = 0; dut_retired = 0; model_accepted = 0;
        prev_alloc = 0; seen_wrap = 0;
        reset = 1;
        clear_in();
        @(negedge clk);
        do_reset();

        // Basic dispatch / complete / retire
        da_v = 1; da_pc = 0; da_p = 33; da_rw = 1;
        db_v = 1; db_pc = 4; db_p = 34; db_rw = 1;
        cycle();
        clear_in();
        set_comp(0, 0, 5);
        set_comp(1, 1, 9);
        #1;
        check("t1_fwd_a", {f_v[0], f_p[0], f_val[0]}, {1'b1, 7'd33, 32'd5});
        check("t1_fwd_b", {f_v[1], f_p[1], f_val[1]}, {1'b1, 7'd34, 32'd9});
        cycle();
        clear_in();
        cycle();
        check("t1_ret_a", {ra_v, ra_pc, ra_val}, {1'b1, 32'd0, 32'd5});
        check("t1_ret_b", {rb_v, rb_pc, rb_val}, {1'b1, 32'd4, 32'd9});

        // Out-of-order completion holds retirement at the head
        da_v = 1; da_pc = 8; da_rw = 1; db_v = 1; db_pc = 12; db_rw = 1;
        cycle();
        clear_in();
        set_comp(0, 3, 77);
        cycle();
        clear_in();
        cycle();
        cycle();
        check("t2_no_retire", ra_v, 0);
        set_comp(1, 2, 66);
        cycle();
        clear_in();
        cycle();
        check("t2_ret_a", {ra_v, ra_pc, ra_val}, {1'b1, 32'd8, 32'd66});
        check("t2_ret_b", {rb_v, rb_pc, rb_val}, {1'b1, 32'd12, 32'd77});

        // Same-index collision: highest port wins
        do_reset();
        for (int c = 0; c < 2; c++) begin
            da_v = 1; da_pc = 32'(100 + 8 * c); da_rw = 1; da_p = 7'(40 + 2 * c);
            db_v = 1; db_pc = 32'(104 + 8 * c); db_rw = 1; db_p = 7'(41 + 2 * c);
            cycle();
        end
        clear_in();
        set_comp(0, 3, 1);
        set_comp(1, 0, 50);
        set_comp(2, 3, 2);
        #1;
        check("coll_fwd_ac", {f_v[0], f_v[2]}, 2'b11);
        cycle();
        clear_in();
        set_comp(0, 1, 51);
        set_comp(1, 2, 52);
        cycle();
        clear_in();
        cycle();
        cycle();
        check("coll_value", {ra_v, ra_pc, ra_val}, {1'b1, 32'd112, 32'd2});

        // Reset with ten entries occupied and a retire pending
        for (int c = 0; c < 5; c++) begin
            rand_disp(1);
            cycle();
        end
        clear_in();
        set_comp(0, mq[0].idx, 32'h11);
        set_comp(1, mq[1].idx, 32'h22);
        cycle();
        do_reset();
        rand_disp(1);
        cycle();
        clear_in();
        cycle();
        check("postrst_no_ret", ra_v, 0);

        // Fill until full; further dispatch is dropped
        do_reset();
        for (int c = 0; c < 31; c++) begin
            rand_disp(1);
            cycle();
        end
        check("fill_full", full, 1);
        check("fill_alloc", alloc_a, 62);
        rand_disp(1);
        cycle();
        check("fill_hold_alloc", alloc_a, 62);
        check("fill_hold_full", full, 1);

        // Randomized sustained traffic with wraparound
        for (int c = 0; c < 2000; c++) begin
            clear_in();
            rand_disp(0);
            for (int p = 0; p < 3; p++) begin
                if ($urandom % 10 < 7) begin
                    if (mq.size() > 0 && ($urandom % 8 != 0))
                        c_i[p] = IW'(mq[$urandom_range(0, mq.size() - 1)].idx);
                    else
                        c_i[p] = IW'($urandom);
                    c_v[p] = 1; c_val[p] = $urandom; c_ma[p] = $urandom;
                end
            end
            cycle();
        end

        // Drain everything still in flight
        for (int n = 0; n < 300 && mq.size() > 0; n++) begin
            int p;
            clear_in();
            p = 0;
            foreach (mq[i]) begin
                if (p < 3 && !mq[i].done) begin
                    c_v[p] = 1; c_i[p] = IW'(mq[i].idx); c_val[p] = $urandom; c_ma[p] = $urandom;
                    p++;
                end
            end
            cycle();
        end
        clear_in();
        check("drain_bound", mq.size(), 0);
        check("drain_not_full", full, 0);
        check("alloc_wrap_seen", seen_wrap, 1);
        check("retired_total", dut_retired, model_accepted);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
